pipe_hazard_ctrl: RTL

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl_pkg.sv | 27 ++
 rtl/hazard_detect.sv | 31 +++
 rtl/pipe_hazard_ctrl.sv | 124 ++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// rtl/pipe_hazard_ctrl_pkg.sv - shared pipeline types and constants for hazard control
package pipe_hazard_ctrl_pkg;

    // Memory-wait FSM: RUN while the pipeline flows, WAIT while a data access is outstanding
    typedef enum logic {
        RUN  = 1'b0,
        WAIT = 1'b1
    } ctrl_state_t;

    // Architectural zero register: writes to it never create a dependency
    localparam logic [4:0] REG_ZERO = 5'd0;

    // Width of the memory-wait timer
    localparam int TIMER_W = 8;

    // True when destination d is a real register that the valid ID instruction reads
    function automatic logic reg_match(
        input logic [4:0] d,
        input logic [4:0] src1,
        input logic [4:0] src2,
        input logic       two_src,
        input logic       valid
    );
        return (d != REG_ZERO) && valid && ((d == src1) || (two_src && (d == src2)));
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational data-hazard detect for the ID stage
module hazard_detect
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic [4:0] ID_src1,
    input  logic [4:0] ID_src2,
    input  logic       ID_two_src,
    input  logic       ID_valid,
    input  logic [4:0] EXE_Dest,
    input  logic       EXE_WB_EN,
    input  logic       EXE_MEM_R_EN,
    input  logic [4:0] MEM_Dest,
    input  logic       MEM_WB_EN,
    input  logic       fwd_en,
    output logic       detect
);

    logic exe_hit;
    logic mem_hit;

    // A load in EXE always stalls a dependent reader; without forwarding any pending write does
    always_comb begin
        exe_hit = reg_match(EXE_Dest, ID_src1, ID_src2, ID_two_src, ID_valid);
        mem_hit = reg_match(MEM_Dest, ID_src1, ID_src2, ID_two_src, ID_valid);
        detect  = EXE_MEM_R_EN && EXE_WB_EN && exe_hit;
        if (!fwd_en) begin
            detect = detect || (EXE_WB_EN && exe_hit) || (MEM_WB_EN && mem_hit);
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall, bubble, flush and freeze control with memory-wait timeout
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       ID_src1,
    input  logic [4:0]       ID_src2,
    input  logic             ID_two_src,
    input  logic             ID_valid,
    input  logic [4:0]       EXE_Dest,
    input  logic             EXE_WB_EN,
    input  logic             EXE_MEM_R_EN,
    input  logic [4:0]       MEM_Dest,
    input  logic             MEM_WB_EN,
    input  logic             MEM_R_EN,
    input  logic             MEM_W_EN,
    input  logic             Br_taken,
    input  logic             fwd_en,
    input  logic             mem_ready,
    output logic             hazard_stall,
    output logic             ID_bubble,
    output logic             Flush,
    output logic             freeze,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt
);

    // Last timer value allowed in WAIT; reaching it without mem_ready aborts the access
    localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(MEM_TIMEOUT - 1);

    ctrl_state_t        state;
    logic [TIMER_W-1:0] timer;
    logic               br_pend;
    logic               mem_acc;
    logic               abort;
    logic               detect;

    hazard_detect u_hazard_detect (
        .ID_src1      (ID_src1),
        .ID_src2      (ID_src2),
        .ID_two_src   (ID_two_src),
        .ID_valid     (ID_valid),
        .EXE_Dest     (EXE_Dest),
        .EXE_WB_EN    (EXE_WB_EN),
        .EXE_MEM_R_EN (EXE_MEM_R_EN),
        .MEM_Dest     (MEM_Dest),
        .MEM_WB_EN    (MEM_WB_EN),
        .fwd_en       (fwd_en),
        .detect       (detect)
    );

    // Same-cycle control: reset masks everything, freeze beats Flush, Flush beats the stall
    always_comb begin
        mem_acc      = MEM_R_EN || MEM_W_EN;
        abort        = (state == WAIT) && !mem_ready && (timer == TIMEOUT_LAST);
        freeze       = rst && mem_acc && !mem_ready && !abort;
        Flush        = rst && (Br_taken || br_pend) && !freeze;
        hazard_stall = rst && detect && !freeze && !Flush;
        ID_bubble    = hazard_stall;
    end

    // Memory-wait FSM; the timer only runs in WAIT and is cleared whenever WAIT is left
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= RUN;
            timer <= '0;
        end else begin
            case (state)
                RUN: begin
                    timer <= '0;
                    if (mem_acc && !mem_ready) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_ready || abort) begin
                        state <= RUN;
                        timer <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    state <= RUN;
                    timer <= '0;
                end
            endcase
        end
    end

    // A branch resolved under freeze is remembered and flushed on the first unfrozen cycle
    always_ff @(posedge clk) begin
        if (!rst) begin
            br_pend <= 1'b0;
        end else if (Flush) begin
            br_pend <= 1'b0;
        end else if (Br_taken && freeze) begin
            br_pend <= 1'b1;
        end
    end

    // Sticky timeout flag, only cleared by reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_err <= 1'b0;
        end else if (abort) begin
            mem_err <= 1'b1;
        end
    end

    // Saturating count of cycles lost to freeze or hazard stall
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if ((freeze || hazard_stall) && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule
